// File: rtl/seq_mult.sv
// Unsigned N x N shift-and-add multiplier with register-file writeback.
// One result every N+2 cycles; LD_REG pulses for one cycle in WB.
module seq_mult #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   DR_In,
    output logic         busy,
    output logic         done,
    output logic         LD_REG,
    output logic [2:0]   DR,
    output logic [N-1:0] D_Out,
    output logic [N-1:0] Prod_Hi,
    output logic         ovf
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [N-1:0]   m;
    logic [N-1:0]   q;
    logic [N:0]     p;
    logic [N:0]     sum;
    logic [CW-1:0]  cnt;
    logic           last;

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // p[N] is always zero between iterations, so the add cannot lose a carry
    always_comb begin
        sum = p;
        if (q[0]) sum = p + {1'b0, m};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m   <= '0;
            q   <= '0;
            p   <= '0;
            cnt <= '0;
            DR  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m   <= A;
                        q   <= B;
                        DR  <= DR_In;
                        p   <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    p   <= {1'b0, sum[N:1]};
                    q   <= {sum[0], q[N-1:1]};
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == WB);
    assign LD_REG  = done;
    assign D_Out   = q;
    assign Prod_Hi = p[N-1:0];
    assign ovf     = |p[N-1:0];

endmodule
